// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console transmitter.
//   tx_state_t     : UART transmitter state encoding
//   MMIO_FINI_WORD : store data that requests finish
package mmio_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] MMIO_FINI_WORD = 32'h00020000;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output.
//   clk_i, rst_i : clock, synchronous active-high reset (flushes pointers/count)
//   push_i, din_i: write strobe and data (ignored while full)
//   pop_i        : read strobe (ignored while empty)
//   dout_o       : head entry, valid whenever empty_o is low
//   full_o       : count == DEPTH
//   empty_o      : count == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; only the occupancy state is cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter. CPU stores with addr[31]=1 queue their low
// byte for 8N1 transmission; a store of FINI_WORD requests finish, and fini_o
// rises once every queued byte has fully left the line.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   dbus_addr_i    : store address (only bit 31 decoded)
//   dbus_wvalid_i  : store valid
//   dbus_wdata_i   : store data
//   stall_o        : combinational; selected byte store blocked by a full FIFO
//   txd_o          : registered UART line, idle high
//   busy_o         : FIFO non-empty or transmitter active
//   fini_o         : sticky finish flag
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 1_000_000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] FINI_WORD  = MMIO_FINI_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_wvalid_i,
  input  logic [31:0] dbus_wdata_i,
  output logic        stall_o,
  output logic        txd_o,
  output logic        busy_o,
  output logic        fini_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          fini_pend_q;
  logic          fini_q;

  logic       sel;
  logic       is_fini;
  logic       push;
  logic       pop;
  logic       baud_last;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       unused_addr;

  assign unused_addr = ^dbus_addr_i[30:0];

  assign sel       = dbus_wvalid_i & dbus_addr_i[31];
  assign is_fini   = (dbus_wdata_i == FINI_WORD);
  // Full is the registered count, so a pop this cycle cannot unblock a store.
  assign stall_o   = sel & ~is_fini & ~fini_pend_q & fifo_full;
  assign push      = sel & ~is_fini & ~fini_pend_q & ~fifo_full;
  assign pop       = (state_q == TX_IDLE) & ~fifo_empty;
  assign baud_last = (baud_q == BAUD_LAST);

  assign txd_o  = txd_q;
  assign busy_o = ~fifo_empty | (state_q != TX_IDLE);
  assign fini_o = fini_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (dbus_wdata_i[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TX_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
      fini_pend_q <= 1'b0;
      fini_q      <= 1'b0;
    end else begin
      if (sel && is_fini) fini_pend_q <= 1'b1;
      if (fini_pend_q && fifo_empty && (state_q == TX_IDLE) && !pop) fini_q <= 1'b1;

      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q <= fifo_dout;
            txd_q   <= 1'b0;
            baud_q  <= '0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_last) begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            baud_q    <= '0;
            state_q   <= TX_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] FINI = 32'h00020000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic        stall, txd, busy, fini;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  mmio_uart_tx #(
    .CLK_HZ     (4_000_000),
    .BAUD       (1_000_000),
    .FIFO_DEPTH (DEPTH),
    .FINI_WORD  (FINI)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .dbus_addr_i   (addr),
    .dbus_wvalid_i (wvalid),
    .dbus_wdata_i  (wdata),
    .stall_o       (stall),
    .txd_o         (txd),
    .busy_o        (busy),
    .fini_o        (fini)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus a frame timer counting cycles since
  // the byte left the queue. The line level is read straight off the 8N1 frame.
  logic [7:0] mq[$];
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_byte = 0;
  bit         m_pend = 0;
  bit         m_fini = 0;
  int         m_sz;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
      m_pend   = 0;
      m_fini   = 0;
    end else begin
      m_sz = mq.size();
      if (m_pend && m_sz == 0 && !m_active) m_fini = 1;
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * C) m_active = 0;
      end else if (m_sz > 0) begin
        m_byte   = mq.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (wvalid && addr[31]) begin
        if (wdata == FINI) m_pend = 1;
        else if (!m_pend && m_sz < DEPTH) mq.push_back(wdata[7:0]);
      end
    end
  end

  function automatic int exp_txd();
    int k;
    if (!m_active) return 1;
    k = m_pos / C;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(m_byte[k-1]);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("txd", int'(txd), exp_txd());
      check("busy", int'(busy), int'(mq.size() > 0 || m_active));
      check("fini", int'(fini), int'(m_fini));
      check("stall", int'(stall),
            int'(wvalid && addr[31] && wdata != FINI && !m_pend && mq.size() == DEPTH));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    addr = a; wdata = d; wvalid = 1'b1;
    @(negedge clk);
    while (stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("store_timeout", n, 0);
    @(posedge clk);
    #1 wvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 5000) check("idle_timeout", n, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int f41[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  int lows, n, stalls;

  initial begin
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fini", int'(fini), 0);
    check("rst_stall", int'(stall), 0);
    @(posedge clk); #1;

    // 1: single byte 0x41, literal frame
    store(32'h80000000, 32'h41);
    @(negedge clk);
    check("t1_pre_txd", int'(txd), 1);
    for (int i = 0; i < 10 * C; i++) begin
      @(negedge clk);
      check("t1_frame", int'(txd), f41[i / C]);
    end
    @(negedge clk);
    check("t1_busy_after", int'(busy), 0);
    @(posedge clk); #1;

    // 2: non-MMIO store ignored
    store(32'h00001000, 32'h41);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!txd || busy) lows++;
    end
    check("t2_quiet", lows, 0);
    @(posedge clk); #1;

    // 3: six back-to-back stores against a 4-deep FIFO
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) store(32'h80000000, 32'h30 + i);
      end
      begin
        repeat (60) begin
          @(negedge clk);
          if (stall) stalls++;
        end
      end
    join
    check("t3_saw_stall", int'(stalls > 0), 1);
    wait_idle();

    // 4: two bytes then finish
    store(32'h80000000, 32'h48);
    store(32'h80000000, 32'h49);
    store(32'h80000010, FINI);
    n = 0;
    while (!fini && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    check("t4_fini_delay", n, 2 * 10 * C + 1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!fini) lows++;
    end
    check("t4_fini_sticky", lows, 0);
    @(posedge clk); #1;
    do_reset();

    // 5: stores after finish are dropped
    store(32'h80000000, FINI);
    store(32'h80000000, 32'h55);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!txd || stall) lows++;
    end
    check("t5_dropped", lows, 0);
    check("t5_fini", int'(fini), 1);
    @(posedge clk); #1;
    do_reset();

    // 6: reset mid-frame
    store(32'h80000000, 32'h5A);
    store(32'h80000000, 32'h11);
    store(32'h80000000, 32'h22);
    idle(8);
    do_reset();
    @(negedge clk);
    check("t6_txd", int'(txd), 1);
    check("t6_busy", int'(busy), 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!txd || busy) lows++;
    end
    check("t6_no_frames", lows, 0);
    @(posedge clk); #1;

    // Randomized traffic checked by the model every cycle
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: store(32'h80000000 | $urandom, $urandom & 32'h0001FFFF);
        6, 7:             store($urandom & 32'h7FFFFFFF, $urandom);
        default:          idle($urandom_range(0, 30));
      endcase
    end
    store(32'h80000000, FINI);
    n = 0;
    while (!fini && n < 8000) begin
      @(posedge clk);
      #1 n++;
    end
    check("rand_fini", int'(fini), 1);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
